// File: rtl/ctrl_pkg.sv
// Shared field map for the 16-bit decode control bundle and the per-stage slice widths.
package ctrl_pkg;

  localparam int SRC1_B      = 15;
  localparam int SRC2_B      = 14;
  localparam int REGDST_B    = 13;
  localparam int EXTOP_B     = 12;
  localparam int EXTPLACE_B  = 11;
  localparam int REGWR_B     = 10;
  localparam int ALUSRC_B    = 9;
  localparam int ALUOP_MSB   = 8;
  localparam int ALUOP_LSB   = 7;
  localparam int DATAINSRC_B = 6;
  localparam int MEMRD_B     = 5;
  localparam int MEMWR_B     = 4;
  localparam int NUMBYTE_MSB = 3;
  localparam int NUMBYTE_LSB = 2;
  localparam int WBDATA_MSB  = 1;
  localparam int WBDATA_LSB  = 0;

  localparam logic [15:0] CTRL_BUBBLE = 16'h0000;

  // MEM slice: {RegWr, reserved 0, DataInSrc, MemRd, MemWr, NumOfByte, WBdata}
  localparam int MEM_SLICE = 9;
  localparam int MEM_REGWR = 8;
  localparam int MEM_MEMRD = 5;
  localparam int MEM_MEMWR = 4;
  // WB slice: {RegWr, WBdata}
  localparam int WB_SLICE  = 3;
  localparam int WB_REGWR  = 2;

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register: holds unless load; on load captures d, or zero when clear.
module pipe_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         load,
  input  logic         clear,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  // clear is only honoured with load, so a frozen pipe never loses its contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_q <= '0;
    else if (load)
      r_q <= clear ? '0 : d;
  end

  assign q = r_q;

endmodule

// File: rtl/ctrl_pipe_carrier.sv
// Carries the decode control bundle through EX/MEM/WB with bubble insertion, memory
// freeze, per-stage hazard/forwarding enables and saturating bubble/retire counters.
module ctrl_pipe_carrier
  import ctrl_pkg::*;
#(
  parameter int CTRL_W = 16,
  parameter int RD_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CTRL_W-1:0]    id_ctrl,
  input  logic                 id_valid,
  input  logic [RD_W-1:0]      id_rd,
  input  logic                 stall,
  input  logic                 kill,
  input  logic                 mem_busy,
  output logic [CTRL_W-1:0]    ex_ctrl,
  output logic                 ex_valid,
  output logic                 mem_valid,
  output logic                 wb_valid,
  output logic [RD_W-1:0]      ex_rd,
  output logic [RD_W-1:0]      mem_rd,
  output logic [RD_W-1:0]      wb_rd,
  output logic [MEM_SLICE-1:0] mem_ctrl,
  output logic [WB_SLICE-1:0]  wb_ctrl,
  output logic                 ex_regwr,
  output logic                 mem_regwr,
  output logic                 wb_regwr,
  output logic                 ex_memrd,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic                 wb_retire,
  output logic [CNT_W-1:0]     bubble_cnt,
  output logic [CNT_W-1:0]     retire_cnt
);

  localparam int EX_W  = 1 + RD_W + CTRL_W;
  localparam int MEM_W = 1 + RD_W + MEM_SLICE;
  localparam int WB_W  = 1 + RD_W + WB_SLICE;

  logic              w_advance;
  logic              w_bubble;
  logic              w_ex_clear;
  logic [EX_W-1:0]   w_ex_d,  w_ex_q;
  logic [MEM_W-1:0]  w_mem_d, w_mem_q;
  logic [WB_W-1:0]   w_wb_d,  w_wb_q;

  logic              r_wb_retire;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_retire_cnt;

  assign w_advance  = ~mem_busy;
  assign w_bubble   = stall | kill;
  // An invalid decode slot is loaded as a bubble so x don't-cares never enter EX
  assign w_ex_clear = w_bubble | ~id_valid;

  assign w_ex_d  = {1'b1, id_rd, id_ctrl};
  assign w_mem_d = {ex_valid, ex_rd,
                    ex_ctrl[REGWR_B], 1'b0, ex_ctrl[DATAINSRC_B:WBDATA_LSB]};
  assign w_wb_d  = {mem_valid, mem_rd,
                    mem_ctrl[MEM_REGWR], mem_ctrl[WBDATA_MSB:WBDATA_LSB]};

  pipe_stage_reg #(.W(EX_W)) u_ex_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_ex_d),
    .load  (w_advance),
    .clear (w_ex_clear),
    .q     (w_ex_q)
  );

  pipe_stage_reg #(.W(MEM_W)) u_mem_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_mem_d),
    .load  (w_advance),
    .clear (1'b0),
    .q     (w_mem_q)
  );

  pipe_stage_reg #(.W(WB_W)) u_wb_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (w_wb_d),
    .load  (w_advance),
    .clear (1'b0),
    .q     (w_wb_q)
  );

  assign {ex_valid,  ex_rd,  ex_ctrl}  = w_ex_q;
  assign {mem_valid, mem_rd, mem_ctrl} = w_mem_q;
  assign {wb_valid,  wb_rd,  wb_ctrl}  = w_wb_q;

  assign ex_regwr  = ex_valid  & ex_ctrl[REGWR_B];
  assign ex_memrd  = ex_valid  & ex_ctrl[MEMRD_B];
  assign mem_regwr = mem_valid & mem_ctrl[MEM_REGWR];
  assign mem_rd_en = mem_valid & mem_ctrl[MEM_MEMRD];
  assign mem_wr_en = mem_valid & mem_ctrl[MEM_MEMWR];
  assign wb_regwr  = wb_valid  & wb_ctrl[WB_REGWR];

  // Retire pulse and counters move only on advancing edges; saturate at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_retire  <= 1'b0;
      r_bubble_cnt <= '0;
      r_retire_cnt <= '0;
    end else if (w_advance) begin
      r_wb_retire <= mem_valid;
      if (mem_valid && (r_retire_cnt != '1))
        r_retire_cnt <= r_retire_cnt + 1'b1;
      if (w_bubble && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else begin
      r_wb_retire <= 1'b0;
    end
  end

  assign wb_retire  = r_wb_retire;
  assign bubble_cnt = r_bubble_cnt;
  assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ctrl_pipe_carrier.sv
// Directed bench for ctrl_pipe_carrier with an instruction-level reference model.
module tb_ctrl_pipe_carrier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id_ctrl;
  logic        id_valid;
  logic [2:0]  id_rd;
  logic        stall, kill, mem_busy;

  logic [15:0] ex_ctrl;
  logic        ex_valid, mem_valid, wb_valid;
  logic [2:0]  ex_rd, mem_rd, wb_rd;
  logic [8:0]  mem_ctrl;
  logic [2:0]  wb_ctrl;
  logic        ex_regwr, mem_regwr, wb_regwr, ex_memrd, mem_rd_en, mem_wr_en, wb_retire;
  logic [15:0] bubble_cnt, retire_cnt;

  int tests = 0;
  int fails = 0;

  ctrl_pipe_carrier #(.CTRL_W(16), .RD_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_rd(id_rd),
    .stall(stall), .kill(kill), .mem_busy(mem_busy),
    .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_regwr(ex_regwr), .mem_regwr(mem_regwr), .wb_regwr(wb_regwr), .ex_memrd(ex_memrd),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .wb_retire(wb_retire),
    .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: each stage holds a whole instruction (valid, rd, full 16-bit bundle)
  logic        m_ex_v = 0, m_mem_v = 0, m_wb_v = 0;
  logic [2:0]  m_ex_rd = 0, m_mem_rd = 0, m_wb_rd = 0;
  logic [15:0] m_ex_c = 0, m_mem_c = 0, m_wb_c = 0;
  logic        m_retire = 0;
  int          m_bub = 0, m_ret = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex_v <= 0; m_mem_v <= 0; m_wb_v <= 0;
      m_ex_rd <= 0; m_mem_rd <= 0; m_wb_rd <= 0;
      m_ex_c <= 0; m_mem_c <= 0; m_wb_c <= 0;
      m_retire <= 0; m_bub <= 0; m_ret <= 0;
    end else if (mem_busy) begin
      m_retire <= 0;
    end else begin
      m_wb_v <= m_mem_v; m_wb_rd <= m_mem_rd; m_wb_c <= m_mem_c;
      m_mem_v <= m_ex_v; m_mem_rd <= m_ex_rd; m_mem_c <= m_ex_c;
      m_retire <= m_mem_v;
      if (m_mem_v && m_ret < 65535) m_ret <= m_ret + 1;
      if (stall || kill) begin
        if (m_bub < 65535) m_bub <= m_bub + 1;
        m_ex_v <= 0; m_ex_rd <= 0; m_ex_c <= 0;
      end else if (id_valid) begin
        m_ex_v <= 1; m_ex_rd <= id_rd; m_ex_c <= id_ctrl;
      end else begin
        m_ex_v <= 0; m_ex_rd <= 0; m_ex_c <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    chk("ex_ctrl",  32'(ex_ctrl),  32'(m_ex_c));
    chk("ex_valid", 32'(ex_valid), 32'(m_ex_v));
    chk("ex_rd",    32'(ex_rd),    32'(m_ex_rd));
    chk("ex_regwr", 32'(ex_regwr), 32'(m_ex_v & m_ex_c[10]));
    chk("ex_memrd", 32'(ex_memrd), 32'(m_ex_v & m_ex_c[5]));
    chk("mem_valid", 32'(mem_valid), 32'(m_mem_v));
    chk("mem_rd",    32'(mem_rd),    32'(m_mem_rd));
    chk("mem_ctrl",  32'(mem_ctrl),  32'({m_mem_c[10], 1'b0, m_mem_c[6:0]}));
    chk("mem_regwr", 32'(mem_regwr), 32'(m_mem_v & m_mem_c[10]));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(m_mem_v & m_mem_c[5]));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(m_mem_v & m_mem_c[4]));
    chk("wb_valid",  32'(wb_valid),  32'(m_wb_v));
    chk("wb_rd",     32'(wb_rd),     32'(m_wb_rd));
    chk("wb_ctrl",   32'(wb_ctrl),   32'({m_wb_c[10], m_wb_c[1:0]}));
    chk("wb_regwr",  32'(wb_regwr),  32'(m_wb_v & m_wb_c[10]));
    chk("wb_retire", 32'(wb_retire), 32'(m_retire));
    chk("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
  end

  task automatic step(input logic v, input logic [15:0] c, input logic [2:0] rd,
                      input logic st, input logic kl, input logic bz);
    id_valid = v; id_ctrl = c; id_rd = rd; stall = st; kill = kl; mem_busy = bz;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 0; id_valid = 0; id_ctrl = 16'h0; id_rd = 0; stall = 0; kill = 0; mem_busy = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    chk("rst ex_valid", 32'(ex_valid), 0);
    chk("rst wb_ctrl", 32'(wb_ctrl), 0);
    chk("rst bubble_cnt", 32'(bubble_cnt), 0);
    chk("rst retire_cnt", 32'(retire_cnt), 0);

    // straight flow
    step(1, 16'h0483, 3, 0, 0, 0);
    chk("flow ex_ctrl", 32'(ex_ctrl), 32'h0483);
    chk("flow ex_regwr", 32'(ex_regwr), 1);
    step(0, 16'h0000, 0, 0, 0, 0);
    chk("flow mem_ctrl", 32'(mem_ctrl), 32'h103);
    step(0, 16'h0000, 0, 0, 0, 0);
    chk("flow wb_ctrl", 32'(wb_ctrl), 32'h7);
    chk("flow wb_rd", 32'(wb_rd), 3);
    chk("flow wb_retire", 32'(wb_retire), 1);
    chk("flow retire_cnt", 32'(retire_cnt), 1);
    step(0, 16'h0000, 0, 0, 0, 0);
    chk("flow retire drop", 32'(wb_retire), 0);

    // load-use stall
    step(1, 16'h0425, 5, 0, 0, 0);
    chk("lu ex_memrd", 32'(ex_memrd), 1);
    step(1, 16'h0483, 2, 1, 0, 0);
    chk("lu ex_valid", 32'(ex_valid), 0);
    chk("lu ex_ctrl", 32'(ex_ctrl), 0);
    chk("lu mem_rd_en", 32'(mem_rd_en), 1);
    chk("lu mem_rd", 32'(mem_rd), 5);
    chk("lu bubble_cnt", 32'(bubble_cnt), 1);
    step(1, 16'h0483, 2, 0, 0, 0);
    chk("lu retire_cnt", 32'(retire_cnt), 2);

    // kill and stall together
    step(1, 16'h0010, 4, 1, 1, 0);
    chk("ks bubble_cnt", 32'(bubble_cnt), 2);
    chk("ks ex_valid", 32'(ex_valid), 0);
    chk("ks mem_rd", 32'(mem_rd), 2);
    chk("ks wb_valid", 32'(wb_valid), 0);
    step(1, 16'h0010, 4, 0, 0, 0);
    chk("pre-busy retire_cnt", 32'(retire_cnt), 3);

    // memory freeze with stall asserted
    for (int i = 0; i < 3; i++) begin
      step(1, 16'h0483, 6, 1, 0, 1);
      chk("busy ex_ctrl", 32'(ex_ctrl), 32'h0010);
      chk("busy ex_rd", 32'(ex_rd), 4);
      chk("busy wb_rd", 32'(wb_rd), 2);
      chk("busy wb_retire", 32'(wb_retire), 0);
      chk("busy bubble_cnt", 32'(bubble_cnt), 2);
      chk("busy retire_cnt", 32'(retire_cnt), 3);
    end
    step(1, 16'h0483, 6, 0, 0, 0);
    chk("resume ex_rd", 32'(ex_rd), 6);
    chk("resume mem_wr_en", 32'(mem_wr_en), 1);
    chk("resume wb_valid", 32'(wb_valid), 0);

    // invalid decode with all-ones don't-cares
    step(0, 16'hFFFF, 7, 0, 0, 0);
    chk("inv ex_ctrl", 32'(ex_ctrl), 0);
    chk("inv ex_rd", 32'(ex_rd), 0);
    chk("inv ex_regwr", 32'(ex_regwr), 0);
    chk("inv bubble_cnt", 32'(bubble_cnt), 2);
    chk("inv retire_cnt", 32'(retire_cnt), 4);

    // bubble counter saturation
    for (int i = 0; i < 70000 && m_bub < 65535; i++)
      step(0, 16'h0000, 0, 1, 0, 0);
    chk("sat reach", 32'(bubble_cnt), 32'hFFFF);
    step(0, 16'h0000, 0, 1, 0, 0);
    chk("sat hold", 32'(bubble_cnt), 32'hFFFF);

    // async reset with three instructions in flight
    step(1, 16'h0483, 1, 0, 0, 0);
    step(1, 16'h0425, 2, 0, 0, 0);
    step(1, 16'h0010, 3, 0, 0, 0);
    chk("fill mem_valid", 32'(mem_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("arst ex_valid", 32'(ex_valid), 0);
    chk("arst mem_valid", 32'(mem_valid), 0);
    chk("arst wb_valid", 32'(wb_valid), 0);
    chk("arst ex_ctrl", 32'(ex_ctrl), 0);
    chk("arst mem_ctrl", 32'(mem_ctrl), 0);
    chk("arst wb_rd", 32'(wb_rd), 0);
    chk("arst wb_retire", 32'(wb_retire), 0);
    chk("arst bubble_cnt", 32'(bubble_cnt), 0);
    chk("arst retire_cnt", 32'(retire_cnt), 0);
    rst_n = 1;
    step(1, 16'h0483, 3, 0, 0, 0);
    chk("post-rst ex_ctrl", 32'(ex_ctrl), 32'h0483);
    step(0, 16'h0000, 0, 0, 0, 0);
    step(0, 16'h0000, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
